// File: rtl/ps2_key_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ps2_key_tx_if
//  Description : Byte handshake between a scan-code source and ps2_key_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_key_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // Upstream scan-code source
    modport master (output tx_data, output tx_valid, input tx_ready);
    // PS/2 transmitter
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/ps2_key_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ps2_key_tx
//  Description : Device-side PS/2 keyboard transmitter. Sends each accepted
//                scan-code byte as an 11-bit frame (start, LSB-first data,
//                odd parity, stop), backs off on host inhibit and resends
//                aborted bytes on its own.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_tx #(
    parameter int CLK_HZ     = 25000000,
    parameter int PS2_HZ     = 12500,
    parameter int GAP_HALVES = 2          // must be >= 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    ps2_key_tx_if.slave     tx,
    input  wire logic       ps2clk_in,
    output logic            ps2clk_out,
    output logic            ps2data_out,
    output logic            tx_done,
    output logic            tx_abort
);

    localparam int HALF    = CLK_HZ / (2 * PS2_HZ);
    localparam int GAP_CYC = GAP_HALVES * HALF;
    localparam int CNT_MAX = (GAP_CYC > HALF) ? GAP_CYC : HALF;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYC - 1);
    localparam logic [3:0]    LAST_BIT = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_HIGH    = 3'd2,
        S_LOW     = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic [10:0]   frame_q;
    logic          retx_q;
    logic          sync1_q;
    logic          sync2_q;
    logic          ready_q;
    logic          clk_q;
    logic          data_q;
    logic          done_q;
    logic          abort_q;

    logic [10:0]   w_frame_d;
    logic          w_accept;

    // Frame bit 0 goes out first: start 0, data LSB first, odd parity, stop 1
    assign w_frame_d = {1'b1, ~^tx.tx_data, tx.tx_data, 1'b0};
    assign w_accept  = tx.tx_valid & ready_q;

    // Two-flop synchronizer for the host clock line; presets to released
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= ps2clk_in;
            sync2_q <= sync1_q;
        end
    end

    // Frame sequencer: half-period timing, inhibit/abort handling, retransmit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            frame_q <= '0;
            retx_q  <= 1'b0;
            ready_q <= 1'b0;
            clk_q   <= 1'b1;
            data_q  <= 1'b1;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    clk_q  <= 1'b1;
                    data_q <= 1'b1;
                    if (w_accept) begin
                        frame_q <= w_frame_d;
                        bit_q   <= 4'd0;
                        cnt_q   <= '0;
                        data_q  <= w_frame_d[0];
                        ready_q <= 1'b0;
                        state_q <= S_HIGH;
                    end else if (!sync2_q) begin
                        ready_q <= 1'b0;
                        state_q <= S_INHIBIT;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end

                S_INHIBIT: begin
                    ready_q <= 1'b0;
                    clk_q   <= 1'b1;
                    data_q  <= 1'b1;
                    if (sync2_q) begin
                        cnt_q   <= '0;
                        state_q <= S_GAP;
                    end
                end

                S_HIGH: begin
                    if (cnt_q == HALF_END) begin
                        cnt_q <= '0;
                        // Host pulled the clock before the stop bit: give up
                        // this attempt but keep the frame for a resend
                        if (!sync2_q && (bit_q < LAST_BIT)) begin
                            clk_q   <= 1'b1;
                            data_q  <= 1'b1;
                            abort_q <= 1'b1;
                            retx_q  <= 1'b1;
                            state_q <= S_INHIBIT;
                        end else begin
                            clk_q   <= 1'b0;
                            state_q <= S_LOW;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_LOW: begin
                    if (cnt_q == HALF_END) begin
                        cnt_q <= '0;
                        clk_q <= 1'b1;
                        if (bit_q == LAST_BIT) begin
                            done_q  <= 1'b1;
                            data_q  <= 1'b1;
                            state_q <= S_GAP;
                        end else begin
                            bit_q   <= bit_q + 4'd1;
                            data_q  <= frame_q[bit_q + 4'd1];
                            state_q <= S_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_GAP: begin
                    clk_q <= 1'b1;
                    if (cnt_q == GAP_END) begin
                        cnt_q <= '0;
                        if (retx_q) begin
                            // Resend the held frame without a new handshake
                            retx_q  <= 1'b0;
                            bit_q   <= 4'd0;
                            data_q  <= frame_q[0];
                            state_q <= S_HIGH;
                        end else begin
                            data_q  <= 1'b1;
                            ready_q <= sync2_q;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        data_q <= 1'b1;
                        cnt_q  <= cnt_q + CW'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    clk_q   <= 1'b1;
                    data_q  <= 1'b1;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx.tx_ready = ready_q;
    assign ps2clk_out  = clk_q;
    assign ps2data_out = data_q;
    assign tx_done     = done_q;
    assign tx_abort    = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_tx
//  Description : Self-checking bench for ps2_key_tx (HALF = 5, GAP_HALVES = 2).
//                Expected frames are queued when a byte is offered and popped
//                as the line monitor assembles frames off the falling edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_tx;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic ps2clk_in = 1'b1;
    logic ps2clk_out;
    logic ps2data_out;
    logic tx_done;
    logic tx_abort;

    ps2_key_tx_if bus ();

    ps2_key_tx #(
        .CLK_HZ     (1000),
        .PS2_HZ     (100),
        .GAP_HALVES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx          (bus.slave),
        .ps2clk_in   (ps2clk_in),
        .ps2clk_out  (ps2clk_out),
        .ps2data_out (ps2data_out),
        .tx_done     (tx_done),
        .tx_abort    (tx_abort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int chk_n  = 0;
    int pass_n = 0;

    logic [10:0] sb[$];

    // Line monitor state (written only by the monitor process)
    logic [10:0] got [0:63];
    int          got_n    = 0;
    int          low_len [0:511];
    int          rise_n   = 0;
    int          fall_at [0:511];
    int          fall_n   = 0;
    int          done_n   = 0;
    int          done_cyc = 0;
    int          abort_n  = 0;
    int          low_cnt  = 0;
    int          bits_n   = 0;
    logic [10:0] bits     = '0;
    logic        prev_clk = 1'b1;

    // Read pointers (written only by the stimulus process)
    int got_rd = 0;
    int low_rd = 0;

    // Watch the PS/2 lines on the falling system-clock edge
    always @(negedge clk) begin
        if (reset) begin
            bits_n  = 0;
            low_cnt = 0;
        end else begin
            if (tx_done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (tx_abort) begin
                abort_n++;
                bits_n = 0;
            end
            if (prev_clk && !ps2clk_out) begin
                fall_at[fall_n % 512] = cyc;
                fall_n++;
                low_cnt = 1;
                bits[bits_n] = ps2data_out;
                bits_n++;
                if (bits_n == 11) begin
                    got[got_n % 64] = bits;
                    got_n++;
                    bits_n = 0;
                end
            end else if (!prev_clk && ps2clk_out) begin
                low_len[rise_n % 512] = low_cnt;
                rise_n++;
            end else if (!ps2clk_out) begin
                low_cnt++;
            end
        end
        prev_clk = ps2clk_out;
    end

    function automatic logic [10:0] mk_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Waits for the offered byte to be taken; acc = cycle of the accept edge
    task automatic wait_accept(output int acc);
        acc = -1;
        for (int i = 0; i < 400; i++) begin
            if (bus.tx_ready) begin
                @(posedge clk);
                step();
                acc = cyc;
                break;
            end
            step();
        end
        chk_n++;
        if (acc < 0) $display("FAIL accept_timeout: byte %h not accepted in 400 cycles", bus.tx_data);
        else pass_n++;
    endtask

    task automatic wait_done(input int prev, output int dc);
        dc = -1;
        for (int i = 0; i < 1500; i++) begin
            if (done_n > prev) begin
                dc = done_cyc;
                break;
            end
            step();
        end
        chk_n++;
        if (dc < 0) $display("FAIL done_timeout: tx_done count %0d, wanted > %0d", done_n, prev);
        else pass_n++;
    endtask

    task automatic wait_ready(input int budget, output int rc);
        rc = -1;
        for (int i = 0; i < budget; i++) begin
            if (bus.tx_ready) begin
                rc = cyc;
                break;
            end
            step();
        end
        chk_n++;
        if (rc < 0) $display("FAIL ready_timeout: tx_ready still 0 after %0d cycles", budget);
        else pass_n++;
    endtask

    task automatic check_frames();
        logic [10:0] exp;
        while (got_rd < got_n) begin
            chk_n++;
            if (sb.size() == 0) begin
                $display("FAIL frame_unexpected: got %b, none expected", got[got_rd % 64]);
            end else begin
                exp = sb.pop_front();
                if (got[got_rd % 64] !== exp)
                    $display("FAIL frame: got %b, expected %b", got[got_rd % 64], exp);
                else pass_n++;
            end
            got_rd++;
        end
    endtask

    task automatic check_lows();
        while (low_rd < rise_n) begin
            chk_n++;
            if (low_len[low_rd % 512] !== 5)
                $display("FAIL low_len: low phase %0d cycles, expected 5", low_len[low_rd % 512]);
            else pass_n++;
            low_rd++;
        end
    endtask

    task automatic test_reset();
        int a;
        int ab0;
        step();
        step();
        chk_n++;
        if ({ps2clk_out, ps2data_out, bus.tx_ready, tx_done, tx_abort} !== 5'b11000)
            $display("FAIL reset_state: clk/data/ready/done/abort %b, expected 11000",
                     {ps2clk_out, ps2data_out, bus.tx_ready, tx_done, tx_abort});
        else pass_n++;
        reset = 1'b0;
        step();
        chk_n++;
        if (bus.tx_ready !== 1'b1) $display("FAIL ready_after_reset: tx_ready %b, expected 1", bus.tx_ready);
        else pass_n++;
        // Start a byte, then reset in the middle of it; the byte is discarded
        bus.tx_data  = 8'h55;
        bus.tx_valid = 1'b1;
        wait_accept(a);
        bus.tx_valid = 1'b0;
        while (cyc < a + 37) step();
        ab0 = abort_n;
        #1 reset = 1'b1;
        #1;
        chk_n++;
        if ({ps2clk_out, ps2data_out, bus.tx_ready} !== 3'b110)
            $display("FAIL reset_midframe: clk/data/ready %b, expected 110",
                     {ps2clk_out, ps2data_out, bus.tx_ready});
        else pass_n++;
        step();
        step();
        step();
        reset = 1'b0;
        chk_n++;
        if (bus.tx_ready !== 1'b0) $display("FAIL ready_at_release: tx_ready %b, expected 0", bus.tx_ready);
        else pass_n++;
        step();
        chk_n++;
        if (bus.tx_ready !== 1'b1) $display("FAIL ready_after_release: tx_ready %b, expected 1", bus.tx_ready);
        else pass_n++;
        chk_n++;
        if (abort_n !== ab0) $display("FAIL reset_no_abort: abort count %0d, expected %0d", abort_n, ab0);
        else pass_n++;
        low_rd = rise_n;
    endtask

    task automatic test_single();
        int a;
        int dc;
        int rc;
        int f0;
        int d0;
        sb.push_back(11'b100_0110_0100);   // 0x32: 0,0,1,0,0,1,1,0,0,0,1 on the wire
        f0 = fall_n;
        d0 = done_n;
        bus.tx_data  = 8'h32;
        bus.tx_valid = 1'b1;
        wait_accept(a);
        bus.tx_valid = 1'b0;
        wait_done(d0, dc);
        chk_n++;
        if (dc - a !== 110) $display("FAIL done_latency: tx_done %0d cycles after accept, expected 110", dc - a);
        else pass_n++;
        wait_ready(40, rc);
        chk_n++;
        if (rc - dc !== 10) $display("FAIL gap_len: tx_ready %0d cycles after done, expected 10", rc - dc);
        else pass_n++;
        chk_n++;
        if (fall_n - f0 !== 11) $display("FAIL fall_count: %0d falling edges, expected 11", fall_n - f0);
        else pass_n++;
        check_frames();
        check_lows();
    endtask

    task automatic test_back_to_back();
        int a1;
        int a2;
        int d0;
        int dc;
        int f0;
        int ab0;
        sb.push_back(mk_frame(8'hF0));
        sb.push_back(mk_frame(8'h5A));
        d0  = done_n;
        f0  = fall_n;
        ab0 = abort_n;
        bus.tx_data  = 8'hF0;
        bus.tx_valid = 1'b1;
        wait_accept(a1);
        bus.tx_data  = 8'h5A;
        wait_accept(a2);
        bus.tx_valid = 1'b0;
        chk_n++;
        if (a2 - a1 < 121) $display("FAIL b2b_accept_gap: %0d cycles, expected >= 121", a2 - a1);
        else pass_n++;
        wait_done(d0 + 1, dc);
        chk_n++;
        if (fall_at[(f0 + 11) % 512] - a1 < 121)
            $display("FAIL b2b_second_start: %0d cycles after first accept, expected >= 121",
                     fall_at[(f0 + 11) % 512] - a1);
        else pass_n++;
        chk_n++;
        if (abort_n !== ab0) $display("FAIL b2b_abort: abort count %0d, expected %0d", abort_n, ab0);
        else pass_n++;
        chk_n++;
        if ({got[(got_n - 2) % 64][9], got[(got_n - 1) % 64][9]} !== 2'b11)
            $display("FAIL b2b_parity: parity bits %b%b, expected 11",
                     got[(got_n - 2) % 64][9], got[(got_n - 1) % 64][9]);
        else pass_n++;
        check_frames();
        check_lows();
    endtask

    task automatic test_inhibit_idle();
        int  r;
        int  rc;
        int  a;
        int  dc;
        int  d0;
        logic bad;
        ps2clk_in = 1'b0;
        repeat (5) step();
        sb.push_back(mk_frame(8'h1C));
        d0 = done_n;
        bus.tx_data  = 8'h1C;
        bus.tx_valid = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            if (bus.tx_ready || !ps2clk_out || !ps2data_out) bad = 1'b1;
            step();
        end
        chk_n++;
        if (bad !== 1'b0) $display("FAIL inhibit_idle: ready/lines moved while inhibited (bad=%b, expected 0)", bad);
        else pass_n++;
        ps2clk_in = 1'b1;
        r = cyc;
        wait_ready(60, rc);
        chk_n++;
        if (rc - r !== 13) $display("FAIL inhibit_release: tx_ready %0d cycles after release, expected 13", rc - r);
        else pass_n++;
        wait_accept(a);
        bus.tx_valid = 1'b0;
        wait_done(d0, dc);
        check_frames();
        check_lows();
    endtask

    task automatic test_abort();
        int a;
        int dc;
        int d0;
        int ab0;
        int f1;
        int g0;
        sb.push_back(mk_frame(8'h5A));
        d0  = done_n;
        ab0 = abort_n;
        g0  = got_n;
        bus.tx_data  = 8'h5A;
        bus.tx_valid = 1'b1;
        wait_accept(a);
        bus.tx_valid = 1'b0;
        // Bit 4 HIGH phase spans cycles a+41..a+45
        while (cyc < a + 41) step();
        ps2clk_in = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (abort_n > ab0) break;
            step();
        end
        chk_n++;
        if (abort_n - ab0 !== 1) $display("FAIL abort_pulse: %0d aborts, expected 1", abort_n - ab0);
        else pass_n++;
        chk_n++;
        if ({ps2clk_out, ps2data_out} !== 2'b11)
            $display("FAIL abort_release: clk/data %b, expected 11", {ps2clk_out, ps2data_out});
        else pass_n++;
        repeat (6) step();
        ps2clk_in = 1'b1;
        f1 = fall_n;
        wait_done(d0, dc);
        chk_n++;
        if (fall_n - f1 !== 11) $display("FAIL retx_falls: %0d falling edges, expected 11", fall_n - f1);
        else pass_n++;
        chk_n++;
        if (got_n - g0 !== 1) $display("FAIL retx_frames: %0d frames, expected 1", got_n - g0);
        else pass_n++;
        chk_n++;
        if (abort_n - ab0 !== 1) $display("FAIL retx_abort_count: %0d aborts, expected 1", abort_n - ab0);
        else pass_n++;
        check_frames();
        check_lows();
    endtask

    task automatic test_stop_inhibit();
        int  a;
        int  dc;
        int  d0;
        int  ab0;
        int  rc;
        logic bad;
        sb.push_back(mk_frame(8'h29));
        d0  = done_n;
        ab0 = abort_n;
        bus.tx_data  = 8'h29;
        bus.tx_valid = 1'b1;
        wait_accept(a);
        bus.tx_valid = 1'b0;
        // Stop-bit HIGH phase spans cycles a+101..a+105
        while (cyc < a + 101) step();
        ps2clk_in = 1'b0;
        wait_done(d0, dc);
        chk_n++;
        if (dc - a !== 110) $display("FAIL stop_done: tx_done %0d cycles after accept, expected 110", dc - a);
        else pass_n++;
        chk_n++;
        if (abort_n !== ab0) $display("FAIL stop_abort: abort count %0d, expected %0d", abort_n, ab0);
        else pass_n++;
        bad = 1'b0;
        repeat (25) begin
            if (bus.tx_ready) bad = 1'b1;
            step();
        end
        chk_n++;
        if (bad !== 1'b0) $display("FAIL stop_inhibit_ready: tx_ready rose while inhibited (bad=%b, expected 0)", bad);
        else pass_n++;
        ps2clk_in = 1'b1;
        wait_ready(60, rc);
        check_frames();
        check_lows();
    endtask

    initial begin
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_inhibit_idle();
        test_abort();
        test_stop_inhibit();
        chk_n++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drain: %0d frames outstanding, expected 0", sb.size());
        else pass_n++;
        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_key_tx.md
Name: ps2_key_tx

Overview:
- Device-side PS/2 keyboard transmitter that replaces direct key_* strobes for boards without a physical keyboard.
- Drives the Orao core's ps2clk/ps2data inputs with real PS/2 frames.
- A script or sequencer upstream hands it scan-code bytes over a valid/ready handshake.
- It emits each byte as an 11-bit frame, honours host inhibit (clock held low) and retransmits aborted bytes.

Parameters:
- CLK_HZ, 25000000, system clock frequency (clk_pixel domain).
- PS2_HZ, 12500, PS/2 bit rate; HALF = CLK_HZ/(2*PS2_HZ) cycles per clock phase, integer division, HALF >= 2.
- GAP_HALVES, 2, idle half-periods (lines released) after each frame before tx_ready returns.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  scan-code byte to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  block accepts a byte this cycle.
- ps2clk_in  in  1  sensed PS/2 clock line (host may pull low); tie 1 when no host drives it.
- ps2clk_out  out  1  PS/2 clock drive; 1 = released/high, 0 = pulled low.
- ps2data_out  out  1  PS/2 data drive; 1 = released/high.
- tx_done  out  1  one-cycle pulse when a frame's stop bit completes.
- tx_abort  out  1  one-cycle pulse when a frame is aborted by host inhibit.

Behaviour:
- Reset, asynchronous: ps2clk_out=1, ps2data_out=1, tx_ready=0, tx_done=0, tx_abort=0, state=IDLE, bit index=0, 2-FF synchronizer for ps2clk_in preset to 1.
- tx_ready is registered: 1 when state=IDLE and the synchronized clock is 1; otherwise 0. It first asserts on the first edge after reset release.
- Accept: tx_valid & tx_ready at an edge. tx_data is latched and frame {stop 1, odd parity ~^data, data[7:0], start 0} is loaded, shifted LSB first. Next state is HIGH, bit index 0, tx_ready drops the next cycle.
- States:
  - IDLE: lines released.
  - INHIBIT: synchronized clock low while idle, or after an abort. Lines released, tx_ready=0. Exits to GAP once the synchronized clock has been 1.
  - HIGH: ps2clk_out=1. ps2data_out = current frame bit, updated on entry. Lasts HALF cycles.
  - LOW: ps2clk_out=0, data held. Lasts HALF cycles. Host samples on the falling edge.
  - GAP: lines released for GAP_HALVES*HALF cycles, then IDLE.
- HIGH end: if synchronized ps2clk_in=0 and bit index <10, abort.
  - Release both lines and pulse tx_abort.
  - Keep the latched frame and set a retransmit flag; go to INHIBIT.
  - Otherwise go to LOW.
- LOW end: if bit index=10, pulse tx_done and go to GAP. Otherwise increment bit index and go to HIGH.
- Inhibit seen during the stop bit (index 10) does not abort; the frame completes.
- INHIBIT/GAP exit with retransmit flag set: restart the same frame at HIGH, index 0, without handshake; clear the flag. Unlimited retries.
- Frame time is 22*HALF cycles. The next accept is possible at the earliest 22*HALF + GAP_HALVES*HALF + 1 cycles after the previous accept.
- tx_valid while tx_ready=0 is ignored; upstream holds it.
- Reset mid-frame: lines release immediately (asynchronous) and the byte is discarded, no tx_abort.
- The internal line is not sampled back; ps2clk_in is only used for inhibit detection.

Test Plan:
- Use CLK_HZ=1000, PS2_HZ=100 (HALF=5), GAP_HALVES=2 throughout.
- Reset: assert reset mid-run -> ps2clk_out=1, ps2data_out=1, tx_ready=0 immediately; tx_ready=1 one cycle after release.
- Send 0x32 -> data during the 11 LOW phases is 0,0,1,0,0,1,1,0,0,0,1 (start, LSB-first 0x32, parity 0, stop). Exactly 11 falling edges, each LOW lasting 5 cycles. tx_done at cycle 110 after accept, tx_ready back 10 cycles later.
- Send 0xF0 then 0x5A back-to-back with tx_valid held -> parity bits are 1 and 1. Second start-bit falling edge is no earlier than 121 cycles after the first accept. Two tx_done pulses, no tx_abort.
- Hold ps2clk_in=0 from before accept -> tx_ready stays 0 and both lines stay 1. Releasing it yields tx_ready=1 after 10 gap cycles plus synchronizer latency.
- Pull ps2clk_in=0 during the HIGH phase of bit 4 of 0x5A -> tx_abort pulse, lines released. After release plus the gap, the full 0x5A frame is retransmitted from the start bit without a new handshake and ends with tx_done.
- Pull ps2clk_in=0 during the stop-bit HIGH phase -> no abort; tx_done pulses; the block then enters INHIBIT until the clock is released.
